bp_be_rec_to_fp: RTL
====================

# bp_be_rec_to_fp

Pipelined recoded-to-IEEE converter on the FP store/move path of the BE calculator. Consumes 65-bit hardfloat recoded operands, which are either native DP or SP-upconverted, as the FP register file holds them. Emits 64-bit IEEE raw values, NaN-boxed when the operand is single precision. Two register stages with a valid/ready handshake and full throughput. Downstream consumers are the store data path and FMV.X/FSGNJ-style moves.

## Interface
Parameters:
- bp_params_p, e_bp_default_cfg, processor config (supplies dword_width_p, word_width_p)
- tag_width_p, 5, width of opaque sideband tag (e.g. rd/ROB id) carried with each operand

Ports:
- clk_i  in  1  clock, rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- flush_i  in  1  kill all in-flight operands
- v_i  in  1  input operand valid
- ready_o  out  1  block accepts operand this cycle (v_i & ready_o = transfer)
- rec_i  in  dp_rec_width_gp (65)  recoded operand, bp_hardfloat_rec_dp_s layout
- rec_sp_not_dp_i  in  1  operand is SP-encoded in DP recoded form
- tag_i  in  tag_width_p  sideband tag
- v_o  out  1  output valid
- ready_and_i  in  1  downstream accepts (v_o & ready_and_i = transfer)
- data_o  out  dword_width_p (64)  IEEE raw result
- sp_not_dp_o  out  1  precision of data_o
- tag_o  out  tag_width_p  tag of data_o

## Operation
- Stage 1 (S1) captures rec_i, rec_sp_not_dp_i and tag_i, then performs the SP downconvert into a registered SP recoded value:
  - exp_code = dp exp[11:9]
  - special = (exp_code==0) or (exp_code>=6)
  - sp exp (9b) = special ? {exp_code, exp[5:0]} : (exp - 1792)[8:0]
  - sp fract = dp fract >> 29
  - sign passes through
  - Exact inverse of the SP→DP upconvert. No rounding: SP-tagged inputs are representable by construction.
- Stage 2 (S2) runs recFNToFN:
  - SP: data_o = {32'hFFFF_FFFF, sp_ieee[31:0]}
  - DP: data_o = dp_ieee[63:0]
  - NaN payloads are not canonicalised. Sign, exponent and payload follow hardfloat recFNToFN.
- Handshake:
  - S2 advances when !s2_v | ready_and_i.
  - S1 advances into S2 when s1_v and S2 advances.
  - ready_o = !flush_i & (!s1_v | s1_advance).
  - v_o = s2_v & !flush_i.
  - Data stays stable while v_o & !ready_and_i.
- Flush: on any cycle with flush_i=1, s1_v and s2_v clear at the next edge. The input is not accepted that cycle and no output transfer occurs.
- Ordering is strictly FIFO, with no drops except on flush.

## Timing
- Reset (asynchronous assert, synchronous-safe release): s1_v=s2_v=0, all data/tag registers=0. Outputs: v_o=0, ready_o=1, data_o=0, sp_not_dp_o=0, tag_o=0.
- Latency: an operand accepted at edge N is visible on v_o/data_o after edge N+1 (2 registers, 1 cycle of output exposure before the consume edge).
- Throughput: 1 operand/cycle while ready_and_i=1.
- Backpressure:
  - With ready_and_i=0, up to 2 operands are held. ready_o drops once both stages are full.
  - In the cycle ready_and_i rises with both stages full, ready_o=1 (pass-through refill).
- Simultaneous events:
  - Flush together with input and output handshakes: the flush wins; nothing is transferred.
  - Reset asserted mid-operation discards contents immediately, regardless of clock.

## Structure
- bp_be_hardfloat_pkg holds:
  - localparam sp_dp_bias_adj_gp = (1<<dp_exp_width_gp)-(1<<sp_exp_width_gp)
  - the exp_code special predicate as a function, shared with the upconverter
- Sub-module bp_be_rec_dp_to_sp (combinational downconvert) is used in S1. The two recFNToFN instances (sp, dp) sit in S2.
- The stage registers use bsg_dff_reset_en-style flops with the async low reset.

## Test plan
- SP 1.0: rec_i = upconvert of raw 0x3F80_0000, sp=1 → data_o=0xFFFF_FFFF_3F80_0000, sp_not_dp_o=1, 2 cycles after accept.
- DP 1.0 round trip: rec_i = recode of 0x3FF0_0000_0000_0000 → data_o=0x3FF0_0000_0000_0000. Sweep SP specials through recode→this block: 0x8000_0000, 0x0000_0001 (subnormal), 0x7F80_0000, 0x7FC0_0000. Each must return boxed and bit-identical.
- Streaming: 8 back-to-back operands with tags 0..7 and ready_and_i=1 → 8 outputs on consecutive cycles, tags in order.
- Backpressure: ready_and_i=0 for 5 cycles while v_i held → exactly 2 accepted, ready_o=0 from the 3rd cycle. Release gives in-order outputs with no loss or duplication.
- Flush with both stages full and v_i=1 → v_o=0 that cycle and the next. The next accepted operand emerges with its own tag.
- Assert reset_n_i low between edges with 2 operands in flight → v_o=0 and ready_o=1 immediately, all outputs 0.

Source files
------------

// File: rtl/bp_be_hardfloat_pkg.sv
// Recoded-float widths, layouts and helpers shared by the BE hardfloat conversion blocks.
package bp_be_hardfloat_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg,
    e_bp_unicore_cfg,
    e_bp_multicore_cfg
  } bp_params_e;

  localparam int dp_exp_width_gp  = 11;
  localparam int dp_sig_width_gp  = 53;
  localparam int sp_exp_width_gp  = 8;
  localparam int sp_sig_width_gp  = 24;
  localparam int dp_rec_width_gp  = dp_exp_width_gp + dp_sig_width_gp + 1;
  localparam int sp_rec_width_gp  = sp_exp_width_gp + sp_sig_width_gp + 1;
  localparam int sp_dp_bias_adj_gp = (1 << dp_exp_width_gp) - (1 << sp_exp_width_gp);

  typedef struct packed {
    logic                       sign;
    logic [dp_exp_width_gp:0]   exp;
    logic [dp_sig_width_gp-2:0] fract;
  } bp_hardfloat_rec_dp_s;

  typedef struct packed {
    logic                       sign;
    logic [sp_exp_width_gp:0]   exp;
    logic [sp_sig_width_gp-2:0] fract;
  } bp_hardfloat_rec_sp_s;

  function automatic int bp_dword_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg, e_bp_unicore_cfg: return 64;
      default:                            return 64;
    endcase
  endfunction

  function automatic int bp_word_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg, e_bp_unicore_cfg: return 32;
      default:                            return 32;
    endcase
  endfunction

  // Zero (000), inf (110) and NaN (111) keep their exponent code verbatim across precisions.
  function automatic logic rec_exp_is_special(input logic [2:0] code);
    return (code == 3'b000) || (code >= 3'b110);
  endfunction

endpackage

// File: rtl/bp_be_dff_reset_en.sv
// Enabled register with asynchronous active-low clear.
module bp_be_dff_reset_en #(
  parameter int width_p = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [width_p-1:0] i_data,
  output logic [width_p-1:0] o_data
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  o_data <= '0;
    else if (i_en) o_data <= i_data;
  end

endmodule

// File: rtl/bp_be_rec_dp_to_sp.sv
// Combinational narrowing of an SP value held in DP recoded form; exact inverse of the upconvert.
module bp_be_rec_dp_to_sp
  import bp_be_hardfloat_pkg::*;
(
  input  bp_hardfloat_rec_dp_s i_dp,
  output bp_hardfloat_rec_sp_s o_sp
);

  // Only the low 9 exponent bits survive, so the bias shift reduces modulo 2^9.
  localparam logic [sp_exp_width_gp:0] bias_adj_lp = (sp_exp_width_gp+1)'(sp_dp_bias_adj_gp);

  logic [2:0] w_code;
  logic       w_special;

  assign w_code    = i_dp.exp[dp_exp_width_gp -: 3];
  assign w_special = rec_exp_is_special(w_code);

  assign o_sp.sign  = i_dp.sign;
  assign o_sp.exp   = w_special ? {w_code, i_dp.exp[sp_exp_width_gp-3:0]}
                                : i_dp.exp[sp_exp_width_gp:0] - bias_adj_lp;
  assign o_sp.fract = (sp_sig_width_gp-1)'(i_dp.fract >> (dp_sig_width_gp - sp_sig_width_gp));

endmodule

// File: rtl/bp_be_rec_fn_to_fn.sv
// Recoded-to-IEEE conversion (hardfloat recFNToFN); NaN payloads pass through untouched.
module bp_be_rec_fn_to_fn #(
  parameter int exp_width_p = 8,
  parameter int sig_width_p = 24
) (
  input  logic [exp_width_p+sig_width_p:0]   i_rec,
  output logic [exp_width_p+sig_width_p-1:0] o_fn
);

  // minNormExp-1 and the recoded-to-IEEE exponent offset (minNormExp-1) in IEEE width.
  localparam logic [exp_width_p:0]   min_norm_m1_lp = (exp_width_p+1)'((1 << (exp_width_p-1)) + 1);
  localparam logic [exp_width_p-1:0] bias_off_lp    = exp_width_p'((1 << (exp_width_p-1)) + 1);

  logic                   w_sign;
  logic [exp_width_p:0]   w_exp;
  logic [sig_width_p-2:0] w_fract;
  logic                   w_zero, w_inf, w_nan, w_sub;
  logic [exp_width_p:0]   w_dist;
  logic [exp_width_p-1:0] w_exp_out;
  logic [sig_width_p-2:0] w_fract_sub, w_fract_out;

  assign {w_sign, w_exp, w_fract} = i_rec;

  assign w_zero = (w_exp[exp_width_p -: 3] == 3'b000);
  assign w_inf  = (w_exp[exp_width_p -: 3] == 3'b110);
  assign w_nan  = (w_exp[exp_width_p -: 3] == 3'b111);
  assign w_sub  = (w_exp <= min_norm_m1_lp);
  assign w_dist = min_norm_m1_lp - w_exp;

  // Subnormal: hidden bit re-enters the fraction, shifted right by the exponent deficit.
  assign w_fract_sub = (sig_width_p-1)'(({!w_zero, w_fract} >> 1) >> w_dist);

  assign w_exp_out   = (w_sub ? '0 : (w_exp[exp_width_p-1:0] - bias_off_lp))
                     | {exp_width_p{w_inf | w_nan}};
  assign w_fract_out = w_sub ? w_fract_sub : (w_inf ? '0 : w_fract);

  assign o_fn = {w_sign, w_exp_out, w_fract_out};

endmodule

// File: rtl/bp_be_rec_to_fp.sv
// Two-stage recoded-to-IEEE converter for the FP store/move path; SP results are NaN-boxed.
module bp_be_rec_to_fp
  import bp_be_hardfloat_pkg::*;
#(
  parameter bp_params_e bp_params_p   = e_bp_default_cfg,
  parameter int         tag_width_p   = 5,
  localparam int        dword_width_p = bp_dword_width(bp_params_p),
  localparam int        word_width_p  = bp_word_width(bp_params_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     flush_i,

  input  logic                     v_i,
  output logic                     ready_o,
  input  bp_hardfloat_rec_dp_s     rec_i,
  input  logic                     rec_sp_not_dp_i,
  input  logic [tag_width_p-1:0]   tag_i,

  output logic                     v_o,
  input  logic                     ready_and_i,
  output logic [dword_width_p-1:0] data_o,
  output logic                     sp_not_dp_o,
  output logic [tag_width_p-1:0]   tag_o
);

  typedef struct packed {
    logic                   sp_not_dp;
    logic [tag_width_p-1:0] tag;
    bp_hardfloat_rec_dp_s   rec;
  } s1_s;

  typedef struct packed {
    logic                   sp_not_dp;
    logic [tag_width_p-1:0] tag;
    bp_hardfloat_rec_dp_s   dp_rec;
    bp_hardfloat_rec_sp_s   sp_rec;
  } s2_s;

  logic [2:1]           r_vld_pipe;
  logic                 w_s1_adv, w_s2_adv, w_s1_en, w_s2_en;
  s1_s                  w_s1_d, w_s1_q;
  s2_s                  w_s2_d, w_s2_q;
  bp_hardfloat_rec_sp_s w_sp_rec;
  logic [sp_exp_width_gp+sp_sig_width_gp-1:0] w_sp_ieee;
  logic [dp_exp_width_gp+dp_sig_width_gp-1:0] w_dp_ieee;

  // Handshake: S2 drains on ready_and_i, S1 refills in the same cycle S2 moves.
  assign w_s2_adv = !r_vld_pipe[2] | ready_and_i;
  assign w_s1_adv = r_vld_pipe[1] & w_s2_adv;
  assign ready_o  = !flush_i & (!r_vld_pipe[1] | w_s1_adv);
  assign w_s1_en  = v_i & ready_o;
  assign w_s2_en  = w_s1_adv & !flush_i;
  assign v_o      = r_vld_pipe[2] & !flush_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_vld_pipe <= '0;
    end else if (flush_i) begin
      r_vld_pipe <= '0;
    end else begin
      if (w_s2_adv) r_vld_pipe[2] <= r_vld_pipe[1];
      if (ready_o)  r_vld_pipe[1] <= v_i;
    end
  end

  assign w_s1_d = '{sp_not_dp: rec_sp_not_dp_i, tag: tag_i, rec: rec_i};

  bp_be_dff_reset_en #(.width_p($bits(s1_s))) s1_reg (
    .i_clk   (clk_i),
    .i_rst_n (reset_n_i),
    .i_en    (w_s1_en),
    .i_data  (w_s1_d),
    .o_data  (w_s1_q)
  );

  bp_be_rec_dp_to_sp dp_to_sp (
    .i_dp (w_s1_q.rec),
    .o_sp (w_sp_rec)
  );

  assign w_s2_d = '{sp_not_dp: w_s1_q.sp_not_dp, tag: w_s1_q.tag,
                    dp_rec: w_s1_q.rec, sp_rec: w_sp_rec};

  bp_be_dff_reset_en #(.width_p($bits(s2_s))) s2_reg (
    .i_clk   (clk_i),
    .i_rst_n (reset_n_i),
    .i_en    (w_s2_en),
    .i_data  (w_s2_d),
    .o_data  (w_s2_q)
  );

  bp_be_rec_fn_to_fn #(.exp_width_p(sp_exp_width_gp), .sig_width_p(sp_sig_width_gp)) sp_to_ieee (
    .i_rec (w_s2_q.sp_rec),
    .o_fn  (w_sp_ieee)
  );

  bp_be_rec_fn_to_fn #(.exp_width_p(dp_exp_width_gp), .sig_width_p(dp_sig_width_gp)) dp_to_ieee (
    .i_rec (w_s2_q.dp_rec),
    .o_fn  (w_dp_ieee)
  );

  assign data_o      = w_s2_q.sp_not_dp ? {{(dword_width_p-word_width_p){1'b1}}, w_sp_ieee}
                                        : w_dp_ieee;
  assign sp_not_dp_o = w_s2_q.sp_not_dp;
  assign tag_o       = w_s2_q.tag;

endmodule
